present_stream_ctrl: RTL and testbench
======================================

Name: present_stream_ctrl

Overview:
Bus-master sequencer directly upstream of the PRESENT register-mapped wrapper. Accepts 64-bit blocks on a valid/ready stream, then programs key, mode and data through the wrapper's chip-select/write-read/address port. It pulses load, polls done, reads back the 64-bit result and presents it on an output valid/ready stream. The wrapper register map is fixed: 0=load, 1..3=key, 4..5=data, 6..7=result, 8=control (write) / done (read).

Parameters:
SETTLE, 4, idle cycles after the load pulse before the first done poll (masks a stale done)
TIMEOUT, 1024, maximum cycles spent in POLL before abort; counter width is $clog2(TIMEOUT+1)

Ports:
clk  in  1  clock
iReset  in  1  reset; asynchronous, active-high
iKey  in  80  key value
iKeyValid  in  1  one-cycle strobe; latches iKey and iMode and sets key_dirty
iMode  in  1  0=encrypt, 1=decrypt (written to wrapper control)
iSValid  in  1  input block valid
oSReady  out  1  input block accepted when iSValid&oSReady
iSData  in  64  plaintext or ciphertext block
oMValid  out  1  result valid
iMReady  in  1  result consumed when oMValid&iMReady
oMData  out  64  result block
oMErr  out  1  qualifies oMData; 1 means timeout and oMData=0
oChipselect  out  1  to wrapper iChipselect
oWriteRead  out  1  1=write, 0=read
oAddress  out  4  wrapper register address
oWdat  out  32  to wrapper idat
iRdat  in  32  from wrapper odat; registered there, valid the cycle after a read is issued

Behaviour:
- Reset (async): FSM=IDLE. All outputs 0. key_reg=0, mode_reg=0, key_dirty=1, so the first block always programs the key.
- All bus outputs are registered. A bus cycle lasts exactly one clock with oChipselect=1. Every non-bus cycle drives oChipselect=0, oWriteRead=0, oAddress=0, oWdat=0.
- oSReady=1 only in IDLE. Acceptance latches iSData into blk_reg.
- iKeyValid is honoured in every state. The new key/mode takes effect at the next block start; an in-flight block keeps its programmed key. If iKeyValid coincides with acceptance, the new key applies to that block.
- States and transitions:
  IDLE: on accept -> WK1 if key_dirty, else WDH.
  WK1/WK2/WK3: write addr 1 = key[79:48], addr 2 = key[47:16], addr 3 = {16'b0, key[15:0]}.
  WCTL: write addr 8 = {31'b0, mode}; clear key_dirty -> WDH.
  WDH/WDL: write addr 4 = blk[63:32], addr 5 = blk[31:0].
  START: write addr 0 = 1.
  SETTLE: CS=0 for SETTLE cycles, which also drops the wrapper load -> POLL.
  POLL: alternates read issue (addr 8) and sample cycle. If iRdat[0]=1 on the sample cycle -> RDH; otherwise reissue.
  RDH: read addr 6; capture iRdat[31:0] into res[63:32] the next cycle.
  RDL: read addr 7; capture into res[31:0].
  OUT: oMValid=1 with stable oMData/oMErr until iMReady; leave OUT the cycle of handshake -> IDLE.
- Latency without a key rewrite, from acceptance to oMValid: 3 writes + SETTLE + 2k poll cycles + 4 read cycles (issue/sample for each half), with k = number of polls.
- Timeout: a cycle counter starts at POLL entry. Reaching TIMEOUT -> OUT with oMData=0, oMErr=1. Set key_dirty so the wrapper is fully reprogrammed next block.
- Back-to-back: a new block is accepted the cycle after the OUT handshake. No overlap.
- iReset asserted mid-operation aborts immediately; the wrapper is reset by the same iReset.

Optional Feature:
PRESENT_STREAM_CTRL_PERF_EN: adds ports oBlkCount[31:0] (completed non-error blocks) and oLastLat[15:0] (acceptance-to-oMValid cycles of the last block, saturating). Both reset to 0 and the count wraps at 2^32. Without the macro the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package present_pkg holds wrapper address constants (ADDR_LOAD=0, ADDR_KEY_HI/MID/LO=1..3, ADDR_DAT_HI/LO=4..5, ADDR_RES_HI/LO=6..7, ADDR_CTRL=8) and the FSM state enum.
- One natural sub-module: present_bus_if, a registered single-beat driver that holds oChipselect/oWriteRead/oAddress/oWdat and provides a one-cycle-delayed read-capture strobe.

Test Plan:
- key=0, mode=0, block 0x0000000000000000, wrapper + core attached -> oMData=0x5579C1387B228445, oMErr=0, and bus trace shows writes 1,2,3,8,4,5,0 in that order.
- Second block 0xFFFFFFFFFFFFFFFF with no new iKeyValid -> key writes skipped (first write addr 4), result 0xA112FFC72F68417B.
- iKeyValid with key=0xFFFF...F (80 bits), mode=1, block 0x3333DCD3213210D2 -> key rewritten, result 0xFFFFFFFFFFFFFFFF.
- Hold iMReady=0 for 20 cycles in OUT -> oMValid and oMData stay stable, oSReady=0, no bus activity.
- Wrapper stub whose done never rises, TIMEOUT=16 -> OUT with oMErr=1, oMData=0 after 16 POLL cycles; next block rewrites the key.
- iReset pulsed during POLL -> all outputs 0 asynchronously, oSReady=1 on the first clock after release.

Source files
------------

// File: rtl/present_pkg.sv
// Shared definitions for the PRESENT stream sequencer: the wrapper register map and the FSM state encoding.
package present_pkg;

    localparam logic [3:0] ADDR_LOAD    = 4'd0;
    localparam logic [3:0] ADDR_KEY_HI  = 4'd1;
    localparam logic [3:0] ADDR_KEY_MID = 4'd2;
    localparam logic [3:0] ADDR_KEY_LO  = 4'd3;
    localparam logic [3:0] ADDR_DAT_HI  = 4'd4;
    localparam logic [3:0] ADDR_DAT_LO  = 4'd5;
    localparam logic [3:0] ADDR_RES_HI  = 4'd6;
    localparam logic [3:0] ADDR_RES_LO  = 4'd7;
    localparam logic [3:0] ADDR_CTRL    = 4'd8;

    typedef enum logic [3:0] {
        ST_IDLE, ST_WK1, ST_WK2, ST_WK3, ST_WCTL, ST_WDH, ST_WDL,
        ST_START, ST_SETTLE, ST_POLL, ST_RDH, ST_RDL, ST_OUT
    } state_t;

endpackage

// File: rtl/present_bus_if.sv
// Registered single-beat driver for the wrapper port; rd_strobe marks the cycle the wrapper's read data is valid.
module present_bus_if
    import present_pkg::*;
(
    input  logic        clk,
    input  logic        iReset,
    input  logic        req,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic        cs,
    output logic        wr,
    output logic [3:0]  address,
    output logic [31:0] wdat,
    output logic        rd_strobe
);

    // One clock per beat; idle cycles force every bus field to zero.
    always_ff @(posedge clk or posedge iReset) begin
        if (iReset) begin
            cs        <= 1'b0;
            wr        <= 1'b0;
            address   <= ADDR_LOAD;
            wdat      <= 32'd0;
            rd_strobe <= 1'b0;
        end else begin
            if (req) begin
                cs      <= 1'b1;
                wr      <= we;
                address <= addr;
                wdat    <= wdata;
            end else begin
                cs      <= 1'b0;
                wr      <= 1'b0;
                address <= ADDR_LOAD;
                wdat    <= 32'd0;
            end
            rd_strobe <= cs & ~wr;
        end
    end

endmodule

// File: rtl/present_stream_ctrl.sv
// Stream-to-bus sequencer in front of the PRESENT register wrapper.
// Optional build macro PRESENT_STREAM_CTRL_PERF_EN adds block count and latency outputs.
module present_stream_ctrl
    import present_pkg::*;
#(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        iReset,
    input  logic [79:0] iKey,
    input  logic        iKeyValid,
    input  logic        iMode,
    input  logic        iSValid,
    output logic        oSReady,
    input  logic [63:0] iSData,
    output logic        oMValid,
    input  logic        iMReady,
    output logic [63:0] oMData,
    output logic        oMErr,
    output logic        oChipselect,
    output logic        oWriteRead,
    output logic [3:0]  oAddress,
    output logic [31:0] oWdat,
    input  logic [31:0] iRdat
`ifdef PRESENT_STREAM_CTRL_PERF_EN
    ,
    output logic [31:0] oBlkCount,
    output logic [15:0] oLastLat
`endif
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t         state_r;
    logic [CW-1:0]  cnt_r;
    logic [79:0]    key_r;
    logic [79:0]    act_key_r;
    logic           mode_r;
    logic           act_mode_r;
    logic           key_dirty_r;
    logic [63:0]    blk_r;
    logic [31:0]    res_hi_r;

    logic           accept_s;
    logic           kdirty_s;
    logic [79:0]    key_sel_s;
    logic           mode_sel_s;
    logic           poll_last_s;
    logic           req_s;
    logic           we_s;
    logic [3:0]     addr_s;
    logic [31:0]    wdat_s;
    logic           rd_strobe_s;

    assign accept_s    = iSValid & oSReady;
    assign kdirty_s    = key_dirty_r | iKeyValid;
    assign key_sel_s   = iKeyValid ? iKey : key_r;
    assign mode_sel_s  = iKeyValid ? iMode : mode_r;
    assign poll_last_s = (cnt_r == CW'(TIMEOUT - 1));

    // Beat request for the next cycle, so the registered bus shows each state's beat while in that state.
    always_comb begin
        req_s  = 1'b0;
        we_s   = 1'b0;
        addr_s = ADDR_LOAD;
        wdat_s = 32'd0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    req_s = 1'b1;
                    we_s  = 1'b1;
                    if (kdirty_s) begin
                        addr_s = ADDR_KEY_HI;
                        wdat_s = key_sel_s[79:48];
                    end else begin
                        addr_s = ADDR_DAT_HI;
                        wdat_s = iSData[63:32];
                    end
                end else begin
                    req_s = 1'b0;
                end
            end
            ST_WK1:  begin req_s = 1'b1; we_s = 1'b1; addr_s = ADDR_KEY_MID; wdat_s = act_key_r[47:16]; end
            ST_WK2:  begin req_s = 1'b1; we_s = 1'b1; addr_s = ADDR_KEY_LO;  wdat_s = {16'd0, act_key_r[15:0]}; end
            ST_WK3:  begin req_s = 1'b1; we_s = 1'b1; addr_s = ADDR_CTRL;    wdat_s = {31'd0, act_mode_r}; end
            ST_WCTL: begin req_s = 1'b1; we_s = 1'b1; addr_s = ADDR_DAT_HI;  wdat_s = blk_r[63:32]; end
            ST_WDH:  begin req_s = 1'b1; we_s = 1'b1; addr_s = ADDR_DAT_LO;  wdat_s = blk_r[31:0]; end
            ST_WDL:  begin req_s = 1'b1; we_s = 1'b1; addr_s = ADDR_LOAD;    wdat_s = 32'd1; end
            ST_SETTLE: begin
                if (cnt_r == CW'(SETTLE - 1)) begin
                    req_s  = 1'b1;
                    addr_s = ADDR_CTRL;
                end else begin
                    req_s = 1'b0;
                end
            end
            ST_POLL: begin
                if (rd_strobe_s && iRdat[0]) begin
                    req_s  = 1'b1;
                    addr_s = ADDR_RES_HI;
                end else if (rd_strobe_s && !poll_last_s) begin
                    req_s  = 1'b1;
                    addr_s = ADDR_CTRL;
                end else begin
                    req_s = 1'b0;
                end
            end
            ST_RDH: begin
                if (rd_strobe_s) begin
                    req_s  = 1'b1;
                    addr_s = ADDR_RES_LO;
                end else begin
                    req_s = 1'b0;
                end
            end
            default: req_s = 1'b0;
        endcase
    end

    present_bus_if u_bus (
        .clk       (clk),
        .iReset    (iReset),
        .req       (req_s),
        .we        (we_s),
        .addr      (addr_s),
        .wdata     (wdat_s),
        .cs        (oChipselect),
        .wr        (oWriteRead),
        .address   (oAddress),
        .wdat      (oWdat),
        .rd_strobe (rd_strobe_s)
    );

    // Main sequencer with registered stream outputs.
    always_ff @(posedge clk or posedge iReset) begin
        if (iReset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            key_r       <= 80'd0;
            act_key_r   <= 80'd0;
            mode_r      <= 1'b0;
            act_mode_r  <= 1'b0;
            key_dirty_r <= 1'b1;
            blk_r       <= 64'd0;
            res_hi_r    <= 32'd0;
            oSReady     <= 1'b0;
            oMValid     <= 1'b0;
            oMData      <= 64'd0;
            oMErr       <= 1'b0;
        end else begin
            if (iKeyValid) begin
                key_r       <= iKey;
                mode_r      <= iMode;
                key_dirty_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        blk_r      <= iSData;
                        act_key_r  <= key_sel_s;
                        act_mode_r <= mode_sel_s;
                        oSReady    <= 1'b0;
                        // The block snapshots the key here, so a key arriving later stays pending.
                        if (kdirty_s) begin
                            key_dirty_r <= 1'b0;
                            state_r     <= ST_WK1;
                        end else begin
                            state_r <= ST_WDH;
                        end
                    end else begin
                        oSReady <= 1'b1;
                    end
                end
                ST_WK1:  state_r <= ST_WK2;
                ST_WK2:  state_r <= ST_WK3;
                ST_WK3:  state_r <= ST_WCTL;
                ST_WCTL: state_r <= ST_WDH;
                ST_WDH:  state_r <= ST_WDL;
                ST_WDL:  state_r <= ST_START;
                ST_START: begin
                    state_r <= ST_SETTLE;
                    cnt_r   <= {CW{1'b0}};
                end
                ST_SETTLE: begin
                    if (cnt_r == CW'(SETTLE - 1)) begin
                        state_r <= ST_POLL;
                        cnt_r   <= {CW{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_POLL: begin
                    if (rd_strobe_s && iRdat[0]) begin
                        state_r <= ST_RDH;
                    end else if (poll_last_s) begin
                        state_r     <= ST_OUT;
                        oMValid     <= 1'b1;
                        oMData      <= 64'd0;
                        oMErr       <= 1'b1;
                        key_dirty_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_RDH: begin
                    if (rd_strobe_s) begin
                        res_hi_r <= iRdat;
                        state_r  <= ST_RDL;
                    end
                end
                ST_RDL: begin
                    if (rd_strobe_s) begin
                        state_r <= ST_OUT;
                        oMValid <= 1'b1;
                        oMErr   <= 1'b0;
                        oMData  <= {res_hi_r, iRdat};
                    end
                end
                ST_OUT: begin
                    if (iMReady) begin
                        state_r <= ST_IDLE;
                        oMValid <= 1'b0;
                        oMErr   <= 1'b0;
                        oMData  <= 64'd0;
                        oSReady <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    oSReady <= 1'b0;
                    oMValid <= 1'b0;
                end
            endcase
        end
    end

`ifdef PRESENT_STREAM_CTRL_PERF_EN
    logic [15:0] lat_r;
    logic        mvalid_q_r;

    // Latency runs from acceptance and is latched when the result first appears.
    always_ff @(posedge clk or posedge iReset) begin
        if (iReset) begin
            lat_r      <= 16'd0;
            mvalid_q_r <= 1'b0;
            oBlkCount  <= 32'd0;
            oLastLat   <= 16'd0;
        end else begin
            mvalid_q_r <= oMValid;
            if (accept_s) begin
                lat_r <= 16'd1;
            end else if (state_r != ST_IDLE && state_r != ST_OUT && lat_r != 16'hFFFF) begin
                lat_r <= lat_r + 16'd1;
            end
            if (oMValid && !mvalid_q_r) begin
                oLastLat <= lat_r;
                if (!oMErr) begin
                    oBlkCount <= oBlkCount + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_present_stream_ctrl.sv
// Scoreboard bench: a behavioural PRESENT-80 wrapper model answers the bus, a monitor checks results.
module tb_present_stream_ctrl;

    logic        clk = 1'b0;
    logic        iReset = 1'b1;
    logic [79:0] iKey = 80'd0;
    logic        iKeyValid = 1'b0;
    logic        iMode = 1'b0;
    logic        iSValid = 1'b0;
    logic        oSReady;
    logic [63:0] iSData = 64'd0;
    logic        oMValid;
    logic        iMReady = 1'b1;
    logic [63:0] oMData;
    logic        oMErr;
    logic        oChipselect;
    logic        oWriteRead;
    logic [3:0]  oAddress;
    logic [31:0] oWdat;
    logic [31:0] iRdat;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    logic [64:0] exp_q[$];
    int          wr_trace[$];
    int          poll_reads = 0;
    logic        stuck = 1'b0;

    always #5 clk = ~clk;

    present_stream_ctrl #(.SETTLE(4), .TIMEOUT(16)) dut (
        .clk(clk), .iReset(iReset), .iKey(iKey), .iKeyValid(iKeyValid), .iMode(iMode),
        .iSValid(iSValid), .oSReady(oSReady), .iSData(iSData),
        .oMValid(oMValid), .iMReady(iMReady), .oMData(oMData), .oMErr(oMErr),
        .oChipselect(oChipselect), .oWriteRead(oWriteRead), .oAddress(oAddress),
        .oWdat(oWdat), .iRdat(iRdat)
    );

    function automatic logic [3:0] sb(input logic [3:0] x);
        case (x)
            4'h0: sb = 4'hC; 4'h1: sb = 4'h5; 4'h2: sb = 4'h6; 4'h3: sb = 4'hB;
            4'h4: sb = 4'h9; 4'h5: sb = 4'h0; 4'h6: sb = 4'hA; 4'h7: sb = 4'hD;
            4'h8: sb = 4'h3; 4'h9: sb = 4'hE; 4'hA: sb = 4'hF; 4'hB: sb = 4'h8;
            4'hC: sb = 4'h4; 4'hD: sb = 4'h7; 4'hE: sb = 4'h1; default: sb = 4'h2;
        endcase
    endfunction

    function automatic logic [3:0] sbi(input logic [3:0] x);
        sbi = 4'h0;
        for (int j = 0; j < 16; j++) begin
            if (sb(4'(j)) == x) sbi = 4'(j);
        end
    endfunction

    function automatic int pidx(input int i);
        pidx = (i == 63) ? 63 : (i * 16) % 63;
    endfunction

    function automatic logic [63:0] present80(input logic [63:0] blk, input logic [79:0] key, input logic dec);
        logic [63:0] rk[32];
        logic [79:0] k;
        logic [63:0] s;
        logic [63:0] t;
        k = key;
        for (int i = 1; i < 32; i++) begin
            rk[i-1] = k[79:16];
            k = {k[18:0], k[79:19]};
            k[79:76] = sb(k[79:76]);
            k[19:15] = k[19:15] ^ 5'(i);
        end
        rk[31] = k[79:16];
        s = blk;
        if (!dec) begin
            for (int r = 0; r < 31; r++) begin
                s = s ^ rk[r];
                for (int n = 0; n < 16; n++) s[n*4 +: 4] = sb(s[n*4 +: 4]);
                for (int b = 0; b < 64; b++) t[pidx(b)] = s[b];
                s = t;
            end
            s = s ^ rk[31];
        end else begin
            s = s ^ rk[31];
            for (int r = 30; r >= 0; r--) begin
                for (int b = 0; b < 64; b++) t[b] = s[pidx(b)];
                s = t;
                for (int n = 0; n < 16; n++) s[n*4 +: 4] = sbi(s[n*4 +: 4]);
                s = s ^ rk[r];
            end
        end
        present80 = s;
    endfunction

    // Wrapper model: register file, load with delayed done, registered read data.
    logic [31:0] m_kh, m_km, m_kl, m_dh, m_dl;
    logic        m_mode, m_done;
    logic [63:0] m_res;
    int          m_busy;
    always @(posedge clk or posedge iReset) begin
        if (iReset) begin
            m_kh <= 32'd0; m_km <= 32'd0; m_kl <= 32'd0; m_dh <= 32'd0; m_dl <= 32'd0;
            m_mode <= 1'b0; m_done <= 1'b0; m_res <= 64'd0; m_busy <= 0; iRdat <= 32'd0;
        end else begin
            iRdat <= 32'd0;
            if (m_busy != 0) begin
                m_busy <= m_busy - 1;
                if (m_busy == 1 && !stuck) m_done <= 1'b1;
            end
            if (oChipselect && oWriteRead) begin
                wr_trace.push_back(int'(oAddress));
                case (oAddress)
                    4'd0: if (oWdat[0]) begin
                        m_done <= 1'b0;
                        m_busy <= 9;
                        m_res  <= present80({m_dh, m_dl}, {m_kh, m_km, m_kl[15:0]}, m_mode);
                    end
                    4'd1: m_kh <= oWdat;
                    4'd2: m_km <= oWdat;
                    4'd3: m_kl <= oWdat;
                    4'd4: m_dh <= oWdat;
                    4'd5: m_dl <= oWdat;
                    4'd8: m_mode <= oWdat[0];
                    default: ;
                endcase
            end else if (oChipselect) begin
                if (oAddress == 4'd8) poll_reads <= poll_reads + 1;
                case (oAddress)
                    4'd6: iRdat <= m_res[63:32];
                    4'd7: iRdat <= m_res[31:0];
                    4'd8: iRdat <= {31'd0, m_done};
                    default: iRdat <= 32'd0;
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every result handshake is compared against the oldest expectation.
    always @(negedge clk) begin
        if (!iReset && oMValid && iMReady) begin
            if (exp_q.size() == 0) check("unexpected_out", {15'd0, oMErr, oMData}, 80'd0);
            else check("result", {15'd0, oMErr, oMData}, {15'd0, exp_q.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [79:0] k, input logic m);
        iKey = k; iMode = m; iKeyValid = 1'b1;
        tick();
        iKeyValid = 1'b0;
    endtask

    task automatic send_block(input logic [63:0] d, input logic [64:0] exp);
        logic acc;
        acc = 1'b0;
        wr_trace.delete();
        exp_q.push_back(exp);
        iSData = d; iSValid = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            acc = oSReady;
            tick();
        end
        iSValid = 1'b0;
        if (!acc) check("accept_timeout", {79'd0, acc}, 80'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 600 && exp_q.size() != 0; i++) tick();
        check("drain", 80'(exp_q.size()), 80'd0);
        tick();
    endtask

    function automatic logic [79:0] trace_word();
        logic [79:0] w;
        w = 80'(wr_trace.size()) << 28;
        for (int i = 0; i < 7; i++) begin
            if (i < wr_trace.size()) w[i*4 +: 4] = 4'(wr_trace[i]);
        end
        trace_word = w;
    endfunction

    logic [63:0] hold_d;
    logic        ok;
    logic [79:0] full_trace;
    logic [79:0] short_trace;

    initial begin
        // 1,2,3,8,4,5,0 packed low nibble first, with the write count above
        full_trace  = (80'd7 << 28) | 80'h0054_8321;
        short_trace = (80'd3 << 28) | 80'h054;
        #1;
        check("reset_outputs", {oSReady, oMValid, oMErr, oChipselect, oWriteRead, oAddress, oMData},
              80'd0);
        tick(); tick();
        iReset = 1'b0;
        tick();

        send_block(64'h0, {1'b0, 64'h5579C1387B228445});
        wait_done();
        check("trace_key_write", trace_word(), full_trace);

        iMReady = 1'b0;
        send_block(64'hFFFFFFFFFFFFFFFF, {1'b0, 64'hA112FFC72F68417B});
        for (int i = 0; i < 200 && !oMValid; i++) tick();
        hold_d = oMData;
        ok = oMValid;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!oMValid || oMData !== hold_d || oSReady || oChipselect) ok = 1'b0;
        end
        check("hold_stable", {79'd0, ok}, 80'd1);
        iMReady = 1'b1;
        wait_done();
        check("trace_no_key", trace_word(), short_trace);

        load_key({80{1'b1}}, 1'b1);
        send_block(64'h3333DCD3213210D2, {1'b0, 64'hFFFFFFFFFFFFFFFF});
        wait_done();
        check("trace_new_key", trace_word(), full_trace);

        stuck = 1'b1;
        poll_reads = 0;
        send_block(64'h1234, {1'b1, 64'h0});
        wait_done();
        check("timeout_polls", 80'(poll_reads), 80'd8);
        stuck = 1'b0;

        send_block(64'h3333DCD3213210D2, {1'b0, 64'hFFFFFFFFFFFFFFFF});
        wait_done();
        check("trace_after_timeout", trace_word(), full_trace);

        send_block(64'h0, {1'b0, 64'h0});
        for (int i = 0; i < 100 && !(oChipselect && !oWriteRead && oAddress == 4'd8); i++) tick();
        #2;
        iReset = 1'b1;
        #1;
        check("async_reset", {oSReady, oMValid, oMErr, oChipselect, oWriteRead, oAddress, oWdat, oMData},
              80'd0);
        exp_q.delete();
        tick(); tick();
        iReset = 1'b0;
        tick();
        check("ready_after_reset", {79'd0, oSReady}, 80'd1);

        send_block(64'h0, {1'b0, 64'h5579C1387B228445});
        wait_done();
        check("trace_after_reset", trace_word(), full_trace);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
